uc_arbiter: RTL and testbench
=============================

# uc_arbiter

Unit clause arbiter: producer-side front end of the unit clause queue. Collects unit literals from NUM_ENG process engines with round-robin arbitration, and filters them against a variable assignment table. Drops duplicates, detects conflicts (literal and its negation both implied) and pushes each newly implied literal exactly once into the unit clause queue through the queue's push/data/full interface.

## Interface
- NUM_ENG, 4: number of engine request ports (≥2).
- DATA_LEN, 512: literal encoding range; LW = $clog2(DATA_LEN) bits, signed two's complement; literal +v / −v = variable v true / false; variables 1..2^(LW−1)−1.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of table, buffer, conflict state (backtrack/restart).
- eng_valid  in  NUM_ENG  engine i offers a literal.
- eng_lit  in  NUM_ENG×LW signed  literal per engine.
- eng_ready  out  NUM_ENG  one-hot grant; literal i consumed when eng_valid[i] & eng_ready[i].
- q_push  out  1  push strobe to queue.
- q_data  out  LW signed  literal pushed.
- q_full  in  1  queue full.
- conflict  out  1  sticky conflict flag.
- conflict_lit  out  LW signed  literal that caused the conflict.
- assigned_cnt  out  LW  number of variables currently recorded in table.

## Operation
- State: assignment table (per variable: assigned bit, polarity bit), one-entry output buffer (buf_valid, buf_lit), round-robin pointer rr (0..NUM_ENG−1), conflict, conflict_lit, assigned_cnt.
- Output side: q_push = buf_valid & ~q_full; q_data = buf_lit. Buffer drains on q_push.
- Grant condition: ~conflict & ~flush & (~buf_valid | q_push). When true, grant the first i with eng_valid[i], scanning rr, rr+1, … (mod NUM_ENG); eng_ready is that one-hot, else all zero. eng_ready never asserts when the condition is false.
- Classification of granted literal L, v = |L|, combinational against current table:
  - L == 0 or L == −2^(LW−1): invalid; consumed, dropped, no state change besides rr.
  - v unassigned: record (assigned=1, polarity=sign), load buffer with L, assigned_cnt+1.
  - v assigned, same polarity: duplicate; consumed, dropped.
  - v assigned, opposite polarity: consumed; conflict←1, conflict_lit←L; not pushed.
- rr ← granted index + 1 (mod NUM_ENG) on every grant; unchanged otherwise.
- Conflict is sticky until flush/reset. After conflict: no further grants. A literal already in the buffer still drains to the queue.
- flush: next edge clears table, buf_valid, conflict, conflict_lit, assigned_cnt, rr. No grant in a flush cycle. A q_push in the flush cycle still occurs if buf_valid & ~q_full.

## Timing
- Reset (rst_n low, async): table clear, buf_valid=0, rr=0, conflict=0, conflict_lit=0, assigned_cnt=0; hence q_push=0, q_data=0, eng_ready=0.
- Latency: literal granted in cycle t appears on q_push/q_data in cycle t+1 if q_full=0 then.
- Throughput: one literal per cycle while q_full stays 0. Buffer refills in the same cycle it drains.
- q_full high: buffer holds, q_push=0, no grants until drain.
- Table recorded at grant edge. A same-variable literal granted in t+1 sees the entry: a duplicate is dropped, the opposite polarity raises a conflict.
- Simultaneous requests on the same variable from two engines resolve serially in rr order across consecutive cycles.
- rst_n deasserting mid-stream: requests are re-arbitrated from rr=0. Engines must hold eng_valid/eng_lit stable until granted.

## Test plan
- Reset then eng_valid=4'b0001, eng_lit[0]=+5, q_full=0 -> eng_ready=4'b0001 in cycle 0, q_push=1 q_data=+5 in cycle 1, assigned_cnt=1.
- All four engines valid with +1,+2,+3,+4 held until granted, rr=0 -> grants 0,1,2,3 on consecutive cycles; queue receives 1,2,3,4 on cycles 1–4.
- Engine0 +7, then engine1 +7 -> second is consumed and not pushed; assigned_cnt=1. Then engine2 −7 -> conflict=1, conflict_lit=−7, no push, all eng_ready 0 thereafter.
- q_full=1 with buffer holding +9 and engine1 valid +10 -> q_push=0, eng_ready=0 while full. On q_full=0: push +9, grant +10 same cycle, push +10 next cycle.
- After conflict, pulse flush -> conflict=0, assigned_cnt=0. Re-offering −7 is pushed normally.
- eng_lit = 0 and = −256 (DATA_LEN=512) -> consumed, no push, counters unchanged.

Source files
------------

// File: rtl/uc_arbiter.sv
// uc_arbiter - producer-side front end of the unit clause queue.
//
// Round-robin arbitrates unit literals from NUM_ENG process engines, filters
// each granted literal against a per-variable assignment table, and pushes
// every newly implied literal exactly once into the unit clause queue.
// Duplicates and invalid encodings are consumed and dropped. An opposite-
// polarity literal for an assigned variable raises a sticky conflict.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   flush         synchronous clear of table, buffer and conflict state
//   eng_valid     per-engine literal offer
//   eng_lit       per-engine signed literal (LW bits, two's complement)
//   eng_ready     one-hot grant; literal consumed on eng_valid & eng_ready
//   q_push        push strobe to the queue
//   q_data        literal being pushed
//   q_full        queue full back-pressure
//   conflict      sticky conflict flag
//   conflict_lit  literal that caused the conflict
//   assigned_cnt  number of variables currently recorded in the table
module uc_arbiter #(
  parameter  int NUM_ENG  = 4,
  parameter  int DATA_LEN = 512,
  localparam int LW       = $clog2(DATA_LEN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [NUM_ENG-1:0]          eng_valid,
  input  logic [NUM_ENG-1:0][LW-1:0]  eng_lit,
  output logic [NUM_ENG-1:0]          eng_ready,
  output logic                        q_push,
  output logic [LW-1:0]               q_data,
  input  logic                        q_full,
  output logic                        conflict,
  output logic [LW-1:0]               conflict_lit,
  output logic [LW-1:0]               assigned_cnt
);

  localparam int VW  = LW - 1;        // variable index width
  localparam int NV  = 1 << VW;       // table entries (entry 0 unused)
  localparam int RRW = $clog2(NUM_ENG);

  logic [NV-1:0]   tbl_asg;           // variable assigned
  logic [NV-1:0]   tbl_pol;           // 1 = assigned false (negative literal)
  logic            buf_valid;
  logic [LW-1:0]   buf_lit;
  logic [RRW-1:0]  rr;

  logic            grant_ok;
  logic            gnt_found;
  logic            gnt;
  logic [RRW-1:0]  gnt_idx;
  logic [RRW-1:0]  rr_next;
  int              idx;

  logic [LW-1:0]   g_lit;
  logic            g_neg;
  logic [LW-1:0]   g_mag;
  logic [VW-1:0]   g_var;
  logic            g_invalid;
  logic            is_new;
  logic            is_conf;

  assign q_push   = buf_valid & ~q_full;
  assign q_data   = buf_lit;
  assign grant_ok = ~conflict & ~flush & (~buf_valid | q_push);

  // Scan rr, rr+1, ... (mod NUM_ENG) for the first requesting engine.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves it unassigned and no latch is inferred.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_ENG; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_ENG) idx = idx - NUM_ENG;
      if (!gnt_found && eng_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = RRW'(idx);
      end
    end
  end

  assign gnt       = grant_ok & gnt_found;
  assign eng_ready = gnt ? (NUM_ENG'(1) << gnt_idx) : '0;
  assign rr_next   = (int'(gnt_idx) == NUM_ENG - 1) ? '0 : gnt_idx + 1'b1;

  // Classification of the granted literal against the current table.
  assign g_lit     = eng_lit[gnt_idx];
  assign g_neg     = g_lit[LW-1];
  assign g_mag     = g_neg ? (~g_lit + 1'b1) : g_lit;
  assign g_var     = g_mag[VW-1:0];
  // Low bits all zero means the literal is 0 or the most negative code;
  // neither names a variable.
  assign g_invalid = (g_lit[VW-1:0] == '0);
  assign is_new    = gnt & ~g_invalid & ~tbl_asg[g_var];
  assign is_conf   = gnt & ~g_invalid &  tbl_asg[g_var] & (tbl_pol[g_var] != g_neg);

  // NOTE: the table lives in flops with reset because flush must clear every
  // entry in one cycle; a RAM could not be cleared that way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_asg      <= '0;
      tbl_pol      <= '0;
      buf_valid    <= 1'b0;
      buf_lit      <= '0;
      rr           <= '0;
      conflict     <= 1'b0;
      conflict_lit <= '0;
      assigned_cnt <= '0;
    end else if (flush) begin
      tbl_asg      <= '0;
      tbl_pol      <= '0;
      buf_valid    <= 1'b0;
      buf_lit      <= '0;
      rr           <= '0;
      conflict     <= 1'b0;
      conflict_lit <= '0;
      assigned_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments, so a later update in this block (a
      // refill) overrides an earlier one (the drain) on the same edge.
      if (q_push) buf_valid <= 1'b0;
      if (gnt)    rr        <= rr_next;
      if (is_new) begin
        tbl_asg[g_var] <= 1'b1;
        tbl_pol[g_var] <= g_neg;
        buf_valid      <= 1'b1;
        buf_lit        <= g_lit;
        assigned_cnt   <= assigned_cnt + 1'b1;
      end
      if (is_conf) begin
        conflict     <= 1'b1;
        conflict_lit <= g_lit;
      end
    end
  end

endmodule

// File: tb/tb_uc_arbiter.sv
// tb_uc_arbiter - directed self-checking bench for uc_arbiter
// (NUM_ENG=4, DATA_LEN=512, LW=9).
module tb_uc_arbiter;

  localparam int NUM_ENG  = 4;
  localparam int DATA_LEN = 512;
  localparam int LW       = 9;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       flush;
  logic [NUM_ENG-1:0]         eng_valid;
  logic [NUM_ENG-1:0][LW-1:0] eng_lit;
  logic [NUM_ENG-1:0]         eng_ready;
  logic                       q_push;
  logic [LW-1:0]              q_data;
  logic                       q_full;
  logic                       conflict;
  logic [LW-1:0]              conflict_lit;
  logic [LW-1:0]              assigned_cnt;

  int total = 0;
  int bad   = 0;

  uc_arbiter #(.NUM_ENG(NUM_ENG), .DATA_LEN(DATA_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .eng_valid    (eng_valid),
    .eng_lit      (eng_lit),
    .eng_ready    (eng_ready),
    .q_push       (q_push),
    .q_data       (q_data),
    .q_full       (q_full),
    .conflict     (conflict),
    .conflict_lit (conflict_lit),
    .assigned_cnt (assigned_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1-2 time units after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  function automatic int slit(input logic [LW-1:0] l);
    return int'($signed(l));
  endfunction

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    eng_valid = '0;
    eng_lit   = '0;
    q_full    = 1'b0;
    #12;
    check("rst_q_push",   int'(q_push), 0);
    check("rst_q_data",   int'(q_data), 0);
    check("rst_ready",    int'(eng_ready), 0);
    check("rst_conflict", int'(conflict), 0);
    check("rst_cnt",      int'(assigned_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Single literal: grant in cycle 0, pushed in cycle 1.
    eng_valid = 4'b0001; eng_lit[0] = 9'd5;
    #1 check("t1_ready", int'(eng_ready), 4'b0001);
    tick();
    eng_valid = '0;
    #1;
    check("t1_push", int'(q_push), 1);
    check("t1_data", slit(q_data), 5);
    check("t1_cnt",  int'(assigned_cnt), 1);
    tick();
    check("t1_idle", int'(q_push), 0);

    // All four engines, rr=0 after flush: grants 0,1,2,3 back to back.
    do_flush();
    check("fl_cnt", int'(assigned_cnt), 0);
    eng_valid = 4'b1111;
    eng_lit[0] = 9'd1; eng_lit[1] = 9'd2; eng_lit[2] = 9'd3; eng_lit[3] = 9'd4;
    #1 check("t2_ready0", int'(eng_ready), 4'b0001);
    for (int c = 1; c <= 4; c++) begin
      tick();
      eng_valid[c-1] = 1'b0;
      #1;
      check("t2_ready", int'(eng_ready), (c < 4) ? (1 << c) : 0);
      check("t2_push",  int'(q_push), 1);
      check("t2_data",  slit(q_data), c);
    end
    check("t2_cnt", int'(assigned_cnt), 4);
    tick();

    // Duplicate then conflict on variable 7.
    do_flush();
    eng_valid = 4'b0001; eng_lit[0] = 9'd7;
    #1 check("t3_ready0", int'(eng_ready), 4'b0001);
    tick();
    eng_valid = 4'b0010; eng_lit[1] = 9'd7;
    #1;
    check("t3_push7",  int'(q_push), 1);
    check("t3_data7",  slit(q_data), 7);
    check("t3_ready1", int'(eng_ready), 4'b0010);
    tick();
    eng_valid = 4'b0100; eng_lit[2] = -9'sd7;
    #1;
    check("t3_dup_push", int'(q_push), 0);
    check("t3_dup_cnt",  int'(assigned_cnt), 1);
    check("t3_ready2",   int'(eng_ready), 4'b0100);
    tick();
    eng_valid = 4'b1111;
    #1;
    check("t3_conflict", int'(conflict), 1);
    check("t3_conf_lit", slit(conflict_lit), -7);
    check("t3_no_push",  int'(q_push), 0);
    check("t3_blocked",  int'(eng_ready), 0);
    tick();
    check("t3_blocked2", int'(eng_ready), 0);
    check("t3_cnt",      int'(assigned_cnt), 1);

    // Flush clears the conflict; -7 is now accepted.
    eng_valid = '0;
    do_flush();
    check("t4_conflict", int'(conflict), 0);
    check("t4_cnt",      int'(assigned_cnt), 0);
    eng_valid = 4'b1000; eng_lit[3] = -9'sd7;
    #1 check("t4_ready", int'(eng_ready), 4'b1000);
    tick();
    eng_valid = '0;
    #1;
    check("t4_push", int'(q_push), 1);
    check("t4_data", slit(q_data), -7);
    tick();

    // Back-pressure: +9 held in buffer while full, +10 waits.
    do_flush();
    q_full = 1'b1;
    eng_valid = 4'b0001; eng_lit[0] = 9'd9;
    #1 check("t5_ready0", int'(eng_ready), 4'b0001);
    tick();
    eng_valid = 4'b0010; eng_lit[1] = 9'd10;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("t5_full_push",  int'(q_push), 0);
      check("t5_full_ready", int'(eng_ready), 0);
      tick();
    end
    q_full = 1'b0;
    #1;
    check("t5_push9",  int'(q_push), 1);
    check("t5_data9",  slit(q_data), 9);
    check("t5_ready1", int'(eng_ready), 4'b0010);
    tick();
    eng_valid = '0;
    #1;
    check("t5_push10", int'(q_push), 1);
    check("t5_data10", slit(q_data), 10);
    check("t5_cnt",    int'(assigned_cnt), 2);
    tick();

    // Invalid encodings 0 and -256 are consumed and dropped.
    do_flush();
    eng_valid = 4'b0001; eng_lit[0] = 9'd0;
    #1 check("t6_ready0", int'(eng_ready), 4'b0001);
    tick();
    eng_valid = 4'b0010; eng_lit[1] = 9'h100;
    #1;
    check("t6_push0",  int'(q_push), 0);
    check("t6_ready1", int'(eng_ready), 4'b0010);
    tick();
    eng_valid = '0;
    #1;
    check("t6_push256", int'(q_push), 0);
    check("t6_cnt",     int'(assigned_cnt), 0);
    check("t6_conflict", int'(conflict), 0);

    // Same variable from two engines resolves serially in rr order (rr=2).
    eng_valid = 4'b1100; eng_lit[2] = 9'd3; eng_lit[3] = -9'sd3;
    #1 check("t7_ready2", int'(eng_ready), 4'b0100);
    tick();
    eng_valid = 4'b1000;
    #1;
    check("t7_ready3", int'(eng_ready), 4'b1000);
    check("t7_push3",  int'(q_push), 1);
    check("t7_data3",  slit(q_data), 3);
    tick();
    eng_valid = '0;
    #1;
    check("t7_conflict", int'(conflict), 1);
    check("t7_conf_lit", slit(conflict_lit), -3);
    check("t7_no_push",  int'(q_push), 0);

    // Asynchronous reset clears the conflict and counters.
    #2 rst_n = 1'b0;
    #1;
    check("t8_conflict", int'(conflict), 0);
    check("t8_cnt",      int'(assigned_cnt), 0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
